// File: rtl/jts16_ramarb.sv
// jts16_ramarb: shares one SDRAM work RAM / VRAM request port between the 68000 and a read-only aux client.
// Define JTS16_ARB_TIMEOUT_EN to add a 1023-cycle memory timeout and a sticky timeout_flag output.
module jts16_ramarb #(
   parameter int AW      = 14,
   parameter int MAXWAIT = 8
)(
   input  logic          rst,
   input  logic          clk,
   input  logic          cpu_ram_cs,
   input  logic          cpu_vram_cs,
   input  logic [AW-1:0] cpu_addr,
   input  logic [15:0]   cpu_din,
   input  logic [1:0]    cpu_dsn,
   input  logic          cpu_rnw,
   output logic [15:0]   cpu_dout,
   output logic          cpu_ok,
   input  logic          aux_req,
   input  logic          aux_sel,
   input  logic [AW-1:0] aux_addr,
   output logic [15:0]   aux_dout,
   output logic          aux_ok,
   output logic          mem_ram_cs,
   output logic          mem_vram_cs,
   output logic [AW-1:0] mem_addr,
   output logic [15:0]   mem_din,
   output logic [1:0]    mem_dsn,
   input  logic [15:0]   mem_data,
`ifdef JTS16_ARB_TIMEOUT_EN
   output logic          timeout_flag,
`endif
   input  logic          mem_ok
);

   localparam int WW = $clog2(MAXWAIT + 1);
   localparam logic [WW-1:0] WMAX = WW'(MAXWAIT);

   typedef enum logic [1:0] { IDLE, CPU, AUX, GAP } state_t;

   state_t        state, next;
   logic [WW-1:0] wait_cnt;
   logic          cpu_served, cpu_abort;
   logic          cpu_cs, cpu_pend, aux_win;
   logic          grant_cpu, grant_aux;
   logic          busy, done, to_expired;
   logic [15:0]   rd_data;

   assign cpu_cs   = cpu_ram_cs | cpu_vram_cs;
   assign cpu_pend = cpu_cs & ~cpu_served;
   assign aux_win  = aux_req & (~cpu_pend | (wait_cnt >= WMAX));
   assign busy     = (state == CPU) || (state == AUX);
   assign done     = busy & (mem_ok | to_expired);
   // A forced completion returns all ones, like an open bus
   assign rd_data  = mem_ok ? mem_data : 16'hffff;

`ifdef JTS16_ARB_TIMEOUT_EN
   logic [9:0] to_cnt;

   assign to_expired = busy && (to_cnt == 10'h3ff) && !mem_ok;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         to_cnt       <= '0;
         timeout_flag <= 1'b0;
      end else begin
         to_cnt <= busy ? to_cnt + 10'd1 : 10'd0;
         if (to_expired) timeout_flag <= 1'b1;
      end
   end
`else
   assign to_expired = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next;
   end

   always_comb begin
      next      = state;
      grant_cpu = 1'b0;
      grant_aux = 1'b0;
      case (state)
         IDLE: begin
            if (aux_win) begin
               next      = AUX;
               grant_aux = 1'b1;
            end else if (cpu_pend) begin
               next      = CPU;
               grant_cpu = 1'b1;
            end
         end
         CPU, AUX: if (done) next = GAP;
         GAP:      next = IDLE;
         default:  next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cpu_dout    <= 16'hffff;
         aux_dout    <= 16'hffff;
         cpu_ok      <= 1'b0;
         aux_ok      <= 1'b0;
         mem_ram_cs  <= 1'b0;
         mem_vram_cs <= 1'b0;
         mem_addr    <= '0;
         mem_din     <= 16'h0000;
         mem_dsn     <= 2'b11;
         wait_cnt    <= '0;
         cpu_served  <= 1'b0;
         cpu_abort   <= 1'b0;
      end else begin
         aux_ok <= 1'b0;
         if (!aux_req || grant_aux || state == AUX) wait_cnt <= '0;
         else if (wait_cnt < WMAX)                  wait_cnt <= wait_cnt + 1'b1;

         // RAM wins if the CPU ever selects both regions at once
         if (grant_cpu) begin
            mem_ram_cs  <= cpu_ram_cs;
            mem_vram_cs <= ~cpu_ram_cs;
            mem_addr    <= cpu_addr;
            mem_din     <= cpu_din;
            mem_dsn     <= cpu_rnw ? 2'b11 : cpu_dsn;
            cpu_abort   <= 1'b0;
         end
         if (grant_aux) begin
            mem_ram_cs  <= ~aux_sel;
            mem_vram_cs <= aux_sel;
            mem_addr    <= aux_addr;
            mem_dsn     <= 2'b11;
         end

         // The memory cycle cannot be aborted; a CPU that lets go just loses the result
         if (state == CPU && !cpu_cs) cpu_abort <= 1'b1;
         if (done) begin
            mem_ram_cs  <= 1'b0;
            mem_vram_cs <= 1'b0;
         end
         if (done && state == CPU && cpu_cs && !cpu_abort) begin
            cpu_dout   <= rd_data;
            cpu_ok     <= 1'b1;
            cpu_served <= 1'b1;
         end
         if (done && state == AUX) begin
            aux_dout <= rd_data;
            aux_ok   <= 1'b1;
         end

         if (!cpu_cs) begin
            cpu_ok     <= 1'b0;
            cpu_served <= 1'b0;
         end
      end
   end

endmodule

// File: doc/jts16_ramarb.md
Name: jts16_ramarb

Overview:
- Arbitrates the single SDRAM-backed work RAM / VRAM request port between two requesters.
- Requester 1 is the main 68000 bus (RAM at c7xxxx, VRAM at 40xxxx).
- Requester 2 is an auxiliary read-only client, used by the NVRAM/debug dump path.
- Sits between the main CPU decode and the jtframe_ramrq-style memory request, and guarantees the cs toggle that the request block needs between accesses.

Parameters:
- AW, 14: word address width (addr[AW:1]).
- MAXWAIT, 8: cycles a pending aux request may wait before it beats a new CPU request.

Ports:
- rst  in  1  asynchronous reset, active high
- clk  in  1  system clock; the only clock
- cpu_ram_cs  in  1  CPU work RAM select, level
- cpu_vram_cs  in  1  CPU VRAM select, level
- cpu_addr  in  AW  CPU word address
- cpu_din  in  16  CPU write data
- cpu_dsn  in  2  {UDSWn,LDSWn}, active-low write strobes
- cpu_rnw  in  1  CPU read (1) / write (0)
- cpu_dout  out  16  read data to CPU
- cpu_ok  out  1  CPU access complete; level
- aux_req  in  1  aux read request; level
- aux_sel  in  1  0 = RAM, 1 = VRAM
- aux_addr  in  AW  aux word address
- aux_dout  out  16  aux read data
- aux_ok  out  1  one-cycle pulse with valid aux_dout
- mem_ram_cs  out  1  memory request, RAM region
- mem_vram_cs  out  1  memory request, VRAM region
- mem_addr  out  AW  memory address
- mem_din  out  16  memory write data
- mem_dsn  out  2  memory write strobes, active low; 2'b11 = read
- mem_data  in  16  memory read data
- mem_ok  in  1  memory done; valid while the cs is high

Behaviour:
- Reset (async, rst=1):
  - state = IDLE.
  - All outputs 0, except cpu_dout = aux_dout = 16'hffff and mem_dsn = 2'b11.
  - Wait counter = 0; CPU-served flag = 0.
- States: IDLE, CPU, AUX, GAP.
- IDLE:
  - CPU pending = (cpu_ram_cs|cpu_vram_cs) and CPU-served flag = 0.
  - Aux pending = aux_req.
  - If both are pending: AUX wins when the wait counter >= MAXWAIT, otherwise CPU wins.
  - On grant, register addr, data and dsn, and drive the mem cs on the next cycle.
  - mem_dsn = 2'b11 on CPU reads and on every aux access.
- CPU / AUX:
  - Hold the mem cs and all registered fields stable until mem_ok = 1.
  - On mem_ok: latch mem_data into the granted requester's dout, drop the mem cs, go to GAP.
  - Latency: mem cs high 1 cycle after grant; requester output 1 cycle after mem_ok.
- GAP:
  - Exactly one cycle with both mem cs low, then IDLE.
  - This guarantees the cs toggle between back-to-back requests.
- cpu_ok:
  - Set when the CPU access completes; sets the CPU-served flag.
  - Stays high while the CPU cs stays high.
  - Both clear the cycle after the CPU cs drops, so a read-modify-write is seen as two requests.
- CPU cs dropping mid-access:
  - The memory access runs to completion; it cannot be aborted.
  - Read data is discarded and cpu_ok does not set.
- aux_ok is a 1-cycle pulse. aux_req must be deasserted or changed by the client the cycle after aux_ok; if still high, it is a new request.
- Wait counter:
  - Increments (saturating at MAXWAIT) each cycle aux_req is high and not granted.
  - Clears when aux is granted or when aux_req is low.
- Concurrent requests: cpu_ram_cs and cpu_vram_cs both high is illegal; RAM takes precedence.

Optional Feature:
- Macro: JTS16_ARB_TIMEOUT_EN.
- With the macro defined:
  - A 10-bit counter runs in CPU and AUX.
  - If mem_ok has not arrived after 1023 cycles, the block forces completion: data = 16'hffff, cpu_ok / aux_ok asserted as normal, then GAP.
  - timeout_flag (extra output, 1 bit) sets sticky and is cleared only by rst.
- Without the macro: no counter and no timeout_flag port; the block waits for mem_ok indefinitely.

Test Plan:
- CPU read, RAM addr 0x0123, mem_ok 3 cycles after cs rises, mem_data = 16'hbeef:
  - mem_ram_cs high 1 cycle after cpu_ram_cs.
  - cpu_dout = beef and cpu_ok = 1 one cycle after mem_ok.
  - cpu_ok clears 1 cycle after cpu_ram_cs falls.
- CPU read-modify-write (cs drops 1 cycle, then a write with dsn = 2'b10, din = 0x55aa):
  - Two separate mem requests separated by ≥1 low cycle.
  - Second request has mem_dsn = 10 and mem_din = 55aa.
- Aux read, VRAM addr 0x3fff, idle CPU:
  - mem_vram_cs asserted, mem_dsn = 11.
  - aux_ok pulses exactly once with aux_dout = mem_data.
- CPU hammering back-to-back while aux_req is held:
  - Aux is granted no later than the first IDLE after its counter reaches 8.
  - The CPU request then waits and completes afterwards.
- rst asserted during an AUX access with mem cs high:
  - Next edge: all mem cs = 0, state IDLE, no aux_ok.
  - After release, a new CPU request is served normally.
- JTS16_ARB_TIMEOUT_EN, mem_ok never arrives:
  - cpu_ok rises after 1023+1 cycles with cpu_dout = ffff.
  - timeout_flag = 1 and stays high until rst.
